// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, PC width and
// the reset/bubble constants.
package fetch_pkg;
  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage (master) and
// instruction memory (slave). At most one request is outstanding.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/pc_gen.sv
// Next-PC selection for the fetch stage: reset, redirect, sequential +4 or hold.
module pc_gen
  import fetch_pkg::*;
(
  input  logic            rst,
  input  logic            redirect,
  input  logic            advance,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc_plus4
);
  assign pc_plus4 = pc + PC_W'(4);

  always_comb begin
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc_plus4;
    end else begin
      pc_next = pc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction memory and feeds IF/ID.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in S_FAULT.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stallf,
  input  logic              pcsrce,
  input  logic [PC_W-1:0]   pctargete,
  fetch_unit_if.master      imem,
  output logic [31:0]       rdf,
  output logic [PC_W-1:0]   pcf,
  output logic [PC_W-1:0]   pcplus4f,
  output logic              validf,
  output logic              fetch_misalign
);
  logic [1:0]      state, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4, target;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d, drop_q, drop_d;
  logic            advance, misaligned, pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target         = pctargete;
  assign misaligned     = pcsrce && (pctargete[1:0] != 2'b00);
  assign pc_misaligned  = pc_q[1:0] != 2'b00;
  assign fetch_misalign = state == S_FAULT;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^pctargete[1:0];
  assign target         = {pctargete[PC_W-1:2], 2'b00};
  assign misaligned     = 1'b0;
  assign pc_misaligned  = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign advance = (state == S_HOLD) && !stallf && !pcsrce;

  pc_gen u_pc_gen (
    .rst      (rst),
    .redirect (pcsrce),
    .advance  (advance),
    .target   (target),
    .pc       (pc_q),
    .pc_next  (pc_d),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_d = state;
    instr_d = instr_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    unique case (state)
      S_REQ: begin
        if (imem.imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = pcsrce;
        end else if (misaligned) begin
          state_d = S_FAULT;
        end
        if (pcsrce) valid_d = 1'b0;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (drop_q || pcsrce) begin
            // Stale response drained; a pending misaligned target faults only now.
            drop_d  = 1'b0;
            state_d = (pcsrce ? misaligned : pc_misaligned) ? S_FAULT : S_REQ;
          end else begin
            instr_d = imem.imem_rdata;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (pcsrce) begin
          drop_d = 1'b1;
        end
        if (pcsrce) valid_d = 1'b0;
      end
      S_HOLD: begin
        if (pcsrce) begin
          valid_d = 1'b0;
          state_d = misaligned ? S_FAULT : S_REQ;
        end else if (!stallf) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        if (pcsrce && !misaligned) state_d = S_REQ;
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign imem.imem_req  = (state == S_REQ) && !rst;
  assign imem.imem_addr = pc_q;

  assign rdf      = valid_q ? instr_q : NOP_INSTR;
  assign pcf      = pc_q;
  assign pcplus4f = pc_plus4;
  assign validf   = valid_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core: owns the fetch PC, issues requests to instruction memory over a req/gnt/rvalid handshake, and presents instruction, PC and PC+4 to the IF/ID pipeline register (`rdf`, `pcf`, `pcplus4f`). It sits upstream of IF/ID and answers the hazard unit's fetch stall and EX-stage branch/jump redirects. When no instruction is ready, it emits a NOP bubble so IF/ID can keep clocking.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stallf`  in  1  hazard-unit stall: hold the presented instruction.
- `pcsrce`  in  1  EX redirect strobe (taken branch/jump), one cycle.
- `pctargete`  in  32  redirect target.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid. At most one request is outstanding.
- `imem_rdata`  in  32  read data.
- `rdf`  out  32  instruction to IF/ID; `NOP_INSTR` when `validf`=0.
- `pcf`  out  32  PC of `rdf`.
- `pcplus4f`  out  32  `pcf + 4`, mod 2^32.
- `validf`  out  1  `rdf` holds a real fetched instruction.
- `fetch_misalign`  out  1  misaligned-redirect fault. Tied 0 unless configured in.

## Operation
- Registers: `pc_q`, `instr_q`, `valid_q`, `drop_q`, `state`.
- States:
  - S_REQ: `imem_req`=1, `imem_addr`=`pc_q`. `imem_gnt` → S_WAIT.
  - S_WAIT: `imem_rvalid` with `drop_q`=0 → load `instr_q`, set `valid_q` → S_HOLD. `imem_rvalid` with `drop_q`=1 → discard data, clear `drop_q` → S_REQ.
  - S_HOLD: present `instr_q`. `stallf`=0 consumes it: `pc_q`←`pc_q`+4, `valid_q`←0 → S_REQ. `stallf`=1 holds all state.
  - S_FAULT: exists only with the config macro.
- Outputs: `rdf` = `valid_q` ? `instr_q` : `NOP_INSTR`; `pcf` = `pc_q`; `pcplus4f` = `pc_q`+4; `validf` = `valid_q`.
- Redirect (`pcsrce`=1) overrides `stallf` and all other events in the same cycle. In every case `pc_q`←`pctargete` and `valid_q`←0. Per state:
  - S_REQ, no gnt → stay S_REQ; new address appears on the next cycle. Changing `imem_addr` before gnt is legal.
  - S_REQ with gnt → S_WAIT with `drop_q`=1.
  - S_WAIT, no rvalid → stay, `drop_q`←1.
  - S_WAIT with rvalid → discard data → S_REQ, `drop_q`←0.
  - S_HOLD → S_REQ.
- PC arithmetic is 32-bit unsigned and wraps: `pc_q`=32'hFFFF_FFFC advances to 32'h0000_0000.
- `imem_req` is forced to 0 while `rst`=1.

## Timing
- Reset values: state S_REQ, `pc_q`=`RESET_PC`, `instr_q`=0, `valid_q`=0, `drop_q`=0. Outputs: `rdf`=`NOP_INSTR`, `pcf`=`RESET_PC`, `pcplus4f`=`RESET_PC`+4, `validf`=0, `imem_req`=0, `fetch_misalign`=0.
- The first `imem_req` is asserted in the first cycle after `rst` deasserts.
- Zero-wait memory (gnt in the request cycle, rvalid the next cycle): `validf` rises 2 cycles after the request cycle. Throughput is 1 instruction per 3 cycles.
- Redirect: the request to `pctargete` is issued the cycle after `pcsrce`, or after the stale response drains.
- `rst` asserted mid-operation returns all state to reset values on the next edge. Responses still in flight from before reset are the memory's responsibility to cancel.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `pctargete[1:0]`≠0 enters S_FAULT.
  - In S_FAULT: `fetch_misalign`=1, no requests, `rdf`=`NOP_INSTR`, `validf`=0, `pcf`=faulting target.
  - Exit only by an aligned redirect or reset.
  - Any outstanding response is dropped via `drop_q` before S_FAULT is entered.
- Not defined: `pctargete[1:0]` is forced to 00, S_FAULT does not exist, and `fetch_misalign` is constant 0.

## Structure
- Shared package `fetch_pkg`: state encoding (S_REQ, S_WAIT, S_HOLD, S_FAULT), `NOP_INSTR` and `RESET_PC` default constants, PC width.
- One sub-module, `pc_gen`: next-PC mux (reset / redirect / +4 / hold) and the +4 adder. FSM and holding registers stay in `fetch_unit`.

## Test plan
- Reset release, zero-wait memory returning 0x0050_0093 → `imem_addr`=0x0; `validf`=1, `rdf`=0x0050_0093, `pcf`=0x0, `pcplus4f`=0x4 two cycles later; next request to 0x4.
- `stallf`=1 for 4 cycles during S_HOLD → `rdf`/`pcf` unchanged and no new `imem_req`; release → `pc_q`=0x8.
- `pcsrce` with target 0x100 while S_WAIT, `imem_rvalid` 3 cycles later with 0xDEAD_BEEF → data discarded, `validf` stays 0, next request to 0x100.
- `pcsrce` and `stallf` together in S_HOLD → redirect wins, `validf`=0, next request to the target.
- `pc_q`=0xFFFF_FFFC consumed → `pcplus4f`=0x0 and next request to 0x0.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x102 → `fetch_misalign`=1, no `imem_req`; redirect to 0x200 → fault clears, request to 0x200. Without the macro: the same stimulus fetches 0x100.
